// File: rtl/sipo_pkg.sv
// Shared definitions for the sipo_deser serial-to-parallel deserialiser.
package sipo_pkg;

    typedef enum logic {
        S_DATA = 1'b0,
        S_PAR  = 1'b1
    } state_t;

    // Bits needed to count 0..width inclusive (bit_cnt reaches WIDTH while awaiting parity).
    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/sipo_shift_core.sv
// WIDTH-bit shift register for sipo_deser; shifts toward the MSB or the LSB on enable.
module sipo_shift_core #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             msb_first,
    input  logic             data_in,
    output logic [WIDTH-1:0] sr_next
);

    logic [WIDTH-1:0] sr;

    // sr_next is the value sr takes on the coming edge, so the top can capture a word including the bit accepted now.
    always_comb begin
        sr_next = sr;
        if (en) begin
            if (msb_first) begin
                sr_next = {sr[WIDTH-2:0], data_in};
            end else begin
                sr_next = {data_in, sr[WIDTH-1:1]};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sr <= '0;
        end else begin
            sr <= sr_next;
        end
    end

endmodule

// File: rtl/sipo_deser.sv
// Serial-in/parallel-out deserialiser with one-cycle word strobe.
// Define SIPO_DESER_PARITY_EN to add a trailing parity bit per word and the parity_err output.
module sipo_deser
    import sipo_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int ODD_PARITY = 0
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          data_in,
    input  logic                          in_valid,
    input  logic                          msb_first,
    output logic [WIDTH-1:0]              data_out,
    output logic                          out_valid,
    output logic [cnt_width(WIDTH)-1:0]   bit_cnt
`ifdef SIPO_DESER_PARITY_EN
    ,
    output logic                          parity_err
`endif
);

    localparam int            CW   = cnt_width(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    if (WIDTH < 2) begin : g_bad_width
        $error("sipo_deser: WIDTH must be 2 or more");
    end
    if (ODD_PARITY != 0 && ODD_PARITY != 1) begin : g_bad_parity
        $error("sipo_deser: ODD_PARITY must be 0 or 1");
    end

    logic             dir_q;
    logic             dir;
    logic             shift_en;
    logic [WIDTH-1:0] word_next;

    // The first bit of a word takes the live msb_first; later bits reuse the latched order.
    assign dir = (bit_cnt == '0) ? msb_first : dir_q;

`ifdef SIPO_DESER_PARITY_EN
    localparam logic [CW-1:0] FULL = CW'(WIDTH);

    state_t state;

    assign shift_en = in_valid && (state == S_DATA);
`else
    assign shift_en = in_valid;
`endif

    sipo_shift_core #(
        .WIDTH(WIDTH)
    ) u_core (
        .clk      (clk),
        .rst      (rst),
        .en       (shift_en),
        .msb_first(dir),
        .data_in  (data_in),
        .sr_next  (word_next)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            data_out  <= '0;
            out_valid <= 1'b0;
            bit_cnt   <= '0;
            dir_q     <= 1'b1;
`ifdef SIPO_DESER_PARITY_EN
            parity_err <= 1'b0;
            state      <= S_DATA;
`endif
        end else begin
            out_valid <= 1'b0;
            if (in_valid) begin
                if (bit_cnt == '0) begin
                    dir_q <= msb_first;
                end
`ifdef SIPO_DESER_PARITY_EN
                // The parity bit is not shifted in, so word_next still holds the data word here.
                if (state == S_PAR) begin
                    data_out   <= word_next;
                    parity_err <= ((^word_next) ^ data_in) != ODD_PARITY[0];
                    out_valid  <= 1'b1;
                    bit_cnt    <= '0;
                    state      <= S_DATA;
                end else if (bit_cnt == LAST) begin
                    bit_cnt <= FULL;
                    state   <= S_PAR;
                end else begin
                    bit_cnt <= bit_cnt + CW'(1);
                end
`else
                if (bit_cnt == LAST) begin
                    data_out  <= word_next;
                    out_valid <= 1'b1;
                    bit_cnt   <= '0;
                end else begin
                    bit_cnt <= bit_cnt + CW'(1);
                end
`endif
            end
        end
    end

endmodule

// File: tb/tb_sipo_deser.sv
// Scoreboard testbench for sipo_deser (WIDTH=8); build with SIPO_DESER_PARITY_EN to cover parity.
module tb_sipo_deser;

    localparam int WIDTH = 8;
`ifdef SIPO_DESER_PARITY_EN
    localparam int PB = 1;
`else
    localparam int PB = 0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       data_in;
    logic       in_valid;
    logic       msb_first;
    logic [7:0] data_out;
    logic       out_valid;
    logic [3:0] bit_cnt;
`ifdef SIPO_DESER_PARITY_EN
    logic       parity_err;
`endif

    typedef struct {
        logic [7:0] word;
        logic       perr;
    } exp_t;

    exp_t exp_q[$];
    int   compared       = 0;
    int   mismatched     = 0;
    int   cycle          = 0;
    int   pulse_cyc      = -1;
    int   prev_pulse_cyc = -1;
    int   word_start     = 0;

    sipo_deser #(
        .WIDTH     (WIDTH),
        .ODD_PARITY(0)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .data_in   (data_in),
        .in_valid  (in_valid),
        .msb_first (msb_first),
        .data_out  (data_out),
        .out_valid (out_valid),
        .bit_cnt   (bit_cnt)
`ifdef SIPO_DESER_PARITY_EN
        ,
        .parity_err(parity_err)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycle++;

    task automatic checkOutput(input string name, input int actual, input int expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Monitor: every strobe must match the oldest outstanding expected word.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && out_valid === 1'b1) begin
            prev_pulse_cyc = pulse_cyc;
            pulse_cyc      = cycle;
            if (exp_q.size() == 0) begin
                compared++;
                mismatched++;
                $display("[TB] FAIL unexpected_out_valid: got pulse with data_out 0x%0h, expected no pulse", data_out);
            end else begin
                e = exp_q.pop_front();
                checkOutput("data_out", int'(data_out), int'(e.word));
`ifdef SIPO_DESER_PARITY_EN
                checkOutput("parity_err", int'(parity_err), int'(e.perr));
`endif
            end
        end
    end

    // Sends seq MSB-of-vector first; msb_first is flipped after bit 0 to show it is latched per word.
    task automatic applyStimulus(input logic [7:0] seq, input logic msb, input logic [7:0] expected,
                                 input int gap_at, input int gap_len, input logic par_bit, input logic perr);
        exp_t e;
        e.word = expected;
        e.perr = perr;
        exp_q.push_back(e);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (i == 0) word_start = cycle;
            if (gap_len > 0 && i == gap_at) begin
                in_valid = 1'b0;
                for (int g = 0; g < gap_len; g++) begin
                    checkOutput("gap_bit_cnt", int'(bit_cnt), gap_at);
                    @(negedge clk);
                end
            end
            data_in   = seq[7-i];
            msb_first = (i == 0) ? msb : ~msb;
            in_valid  = 1'b1;
        end
`ifdef SIPO_DESER_PARITY_EN
        @(negedge clk);
        data_in  = par_bit;
        in_valid = 1'b1;
`endif
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            in_valid = 1'b0;
            data_in  = 1'b0;
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [7:0] partial;
        rst       = 1'b1;
        in_valid  = 1'b0;
        data_in   = 1'b0;
        msb_first = 1'b1;
        repeat (2) @(negedge clk);
        checkOutput("reset_data_out", int'(data_out), 0);
        checkOutput("reset_out_valid", int'(out_valid), 0);
        checkOutput("reset_bit_cnt", int'(bit_cnt), 0);
`ifdef SIPO_DESER_PARITY_EN
        checkOutput("reset_parity_err", int'(parity_err), 0);
`endif
        rst = 1'b0;

        $display("[TB] scenario 1: MSB-first 1,0,1,1,0,0,1,0");
        applyStimulus(8'b1011_0010, 1'b1, 8'hB2, 0, 0, 1'b0, 1'b0);
        idle(2);
        checkOutput("s1_latency", pulse_cyc - word_start, 8 + PB);
        checkOutput("s1_bit_cnt", int'(bit_cnt), 0);

        $display("[TB] scenario 2: LSB-first same bits");
        applyStimulus(8'b1011_0010, 1'b0, 8'h4D, 0, 0, 1'b0, 1'b0);
        idle(2);
        checkOutput("s2_bit_cnt", int'(bit_cnt), 0);

        $display("[TB] scenario 3: 3-cycle gap after bit 4");
        applyStimulus(8'b1011_0010, 1'b1, 8'hB2, 4, 3, 1'b0, 1'b0);
        idle(2);
        checkOutput("s3_latency", pulse_cyc - word_start, 11 + PB);

        $display("[TB] scenario 4: reset after 5 bits");
        partial = 8'b1011_0010;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            data_in   = partial[7-i];
            msb_first = 1'b1;
            in_valid  = 1'b1;
        end
        @(negedge clk);
        in_valid = 1'b0;
        rst      = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("s4_reset_data_out", int'(data_out), 0);
        checkOutput("s4_reset_bit_cnt", int'(bit_cnt), 0);
        applyStimulus(8'b1111_0000, 1'b1, 8'hF0, 0, 0, 1'b0, 1'b0);
        idle(2);

        $display("[TB] scenario 5: back-to-back A5, 3C");
        applyStimulus(8'hA5, 1'b1, 8'hA5, 0, 0, 1'b0, 1'b0);
        applyStimulus(8'h3C, 1'b1, 8'h3C, 0, 0, 1'b0, 1'b0);
        idle(2);
        checkOutput("s5_spacing", pulse_cyc - prev_pulse_cyc, 8 + PB);

`ifdef SIPO_DESER_PARITY_EN
        $display("[TB] scenario 6: even parity good and bad");
        applyStimulus(8'hB2, 1'b1, 8'hB2, 0, 0, 1'b0, 1'b0);
        applyStimulus(8'hB2, 1'b1, 8'hB2, 0, 0, 1'b1, 1'b1);
        idle(2);
`endif

        checkOutput("pending_words", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/sipo_deser.md
# sipo_deser

Parametrised serial-in/parallel-out deserialiser, the generalised successor to the team's fixed 4-bit SIPO shift register. It accepts one serial bit per qualified clock, assembles `WIDTH`-bit words in either MSB-first or LSB-first order, and presents each completed word with a one-cycle valid strobe. It sits between a serial receive front end and word-oriented downstream logic. Optional per-word parity checking is compiled in by macro.

## Interface
Parameters:
- `WIDTH`, default 8, data word width in bits; legal range is 2 or more.
- `ODD_PARITY`, default 0, parity sense when parity is enabled: 0 = even, 1 = odd.

Ports:
- `clk`  in  1  single clock; all logic is rising-edge.
- `rst`  in  1  synchronous, active-high reset.
- `data_in`  in  1  serial data bit.
- `in_valid`  in  1  qualifies `data_in`; the bit is consumed on a rising edge with `in_valid`=1.
- `msb_first`  in  1  bit order: 1 = first received bit lands in the MSB; 0 = first received bit lands in the LSB.
- `data_out`  out  `WIDTH`  last completed word; held until the next word completes.
- `out_valid`  out  1  one-cycle pulse marking a new `data_out`.
- `bit_cnt`  out  `$clog2(WIDTH+1)`  count of data bits received in the current word.
- `parity_err`  out  1  present only with `SIPO_DESER_PARITY_EN`; valid while `out_valid`=1.

## Operation
- Reset values: `data_out`=0, `out_valid`=0, `bit_cnt`=0, `parity_err`=0, internal shift register=0, state=`S_DATA`.
- **MSB-first shift:** `sr <= {sr[WIDTH-2:0], data_in}`.
- **LSB-first shift:** `sr <= {data_in, sr[WIDTH-1:1]}`.
- **Bit order latch:** `msb_first` is sampled on the first accepted bit of a word (`bit_cnt`==0) and held for that word. Changes mid-word are ignored.
- **Gaps:** `in_valid`=0 holds all state. Gaps of any length inside a word are legal.
- **State machine:** two states, `S_DATA` and `S_PAR`.
  - In `S_DATA`, each accepted bit shifts and increments `bit_cnt`.
  - On the `WIDTH`-th accepted bit without parity: the assembled word, including this bit, is loaded into `data_out`; `out_valid` pulses; `bit_cnt` returns to 0; the state stays `S_DATA`.
  - With parity, the `WIDTH`-th bit instead moves the state to `S_PAR`, with `bit_cnt`=`WIDTH`.
  - In `S_PAR`, the next accepted bit is the parity bit. The word is delivered, `parity_err` is computed, `bit_cnt` returns to 0, and the state returns to `S_DATA`.
- **Back-to-back words:** no idle cycle is needed between words. The bit accepted on the edge after completion is bit 0 of the next word.
- **Reset mid-word:** the partial word is discarded. `data_out` is cleared to 0 and no `out_valid` is issued.

## Timing
- `out_valid` rises in the cycle after the edge that accepts the final bit of a word (the final data bit, or the parity bit when parity is enabled). It lasts exactly one cycle.
- Minimum spacing between `out_valid` pulses is `WIDTH` cycles, or `WIDTH+1` with parity.
- `data_out` and `parity_err` change only together with an `out_valid` assertion, or on reset.
- `bit_cnt` updates on the same edge that accepts a bit.

## Configuration
- Macro: `SIPO_DESER_PARITY_EN`.
- **Defined:** the `parity_err` port and the `S_PAR` state exist.
  - `parity_err` = (XOR of the data bits and the parity bit) != `ODD_PARITY`.
  - The word is still delivered when `parity_err`=1.
- **Undefined:** there is no `parity_err` port and no `S_PAR` state. Every `WIDTH`-th bit completes a word, and `ODD_PARITY` is unused.

## Structure
- Shared package `sipo_pkg` holds:
  - the state encodings `S_DATA`=1'b0 and `S_PAR`=1'b1;
  - the counter-width constant function used for `bit_cnt`.
- Sub-module `sipo_shift_core` holds the `WIDTH`-bit shift register with a direction select and a shift enable.
- The top level holds the FSM, the counter, the output registers and the parity logic.

## Test plan
All scenarios use `WIDTH`=8 and a 10 ns clock.
1. MSB-first, `in_valid` held high, bits 1,0,1,1,0,0,1,0 → one `out_valid` pulse, `data_out`=8'hB2, `bit_cnt` back to 0.
2. LSB-first, same bit sequence → `data_out`=8'h4D.
3. Scenario 1 with `in_valid` low for 3 cycles after bit 4 → `bit_cnt` holds at 4 during the gap; result is still 8'hB2, delivered 3 cycles later.
4. `rst` asserted for one cycle after 5 bits, then 8 new bits 1,1,1,1,0,0,0,0 (MSB-first) → no pulse for the partial word; then `data_out`=8'hF0.
5. 16 consecutive bits encoding 8'hA5 then 8'h3C → two `out_valid` pulses exactly 8 cycles apart, with the correct words.
6. Parity build, even parity, 8'hB2 followed by parity bit 0 → `parity_err`=0. Same word followed by parity bit 1 → `parity_err`=1 and `data_out`=8'hB2.
